complete_seq_ctrl: RTL

//   Sequencer for the three-block Complete datapath on the DE10-Lite board.
//   - Turns SW[9:8] into a one-hot block select.
//   - Debounces KEY[1] and uses it to step through a two-operand entry from SW[7:0].
//   - Fires a one-cycle start to the selected block, then waits for that block's

---
 rtl/complete_seq_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/complete_seq_ctrl.sv
// complete_seq_ctrl: operator sequencer for the three-block Complete datapath.
// Synchronises the board switches and key, debounces the key into a single
// press pulse, walks a two-operand entry, fires one start pulse to the chosen
// block and then waits for that block's done or a timeout.
module complete_seq_ctrl #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              key_n,
  input  logic [2:0]        done,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        blk_sel,
  output logic              start,
  output logic              busy,
  output logic              result_valid,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_B = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        mode_p0, mode_p1;
  logic              key_p0, key_p1;
  logic [DATA_W-1:0] data_p0, data_p1;
  logic [DCW-1:0]    deb_cnt;
  logic              deb_level;
  logic              press;
  logic [1:0]        mode_cap;
  logic [TCW-1:0]    tmo_cnt;
  logic              mode_chg;

  // Switch pair to one-hot block select; both 1x codes address block 3.
  function automatic logic [2:0] mode_to_sel(input logic [1:0] m);
    logic [2:0] sel;
    if (m[1])      sel = 3'b100;
    else if (m[0]) sel = 3'b010;
    else           sel = 3'b001;
    return sel;
  endfunction

  // Two-flop synchronisers for the control inputs; key idles released (1).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_p0 <= 2'b00;
      mode_p1 <= 2'b00;
      key_p0  <= 1'b1;
      key_p1  <= 1'b1;
    end else begin
      mode_p0 <= mode;
      mode_p1 <= mode_p0;
      key_p0  <= key_n;
      key_p1  <= key_p0;
    end
  end

  // Two-flop synchroniser for the operand switches; only read at latch events.
  always_ff @(posedge clk) begin
    data_p0 <= data_in;
    data_p1 <= data_p0;
  end

  // Debounce: accept a new key level once it has differed for DEBOUNCE_CYCLES
  // consecutive clocks; a 1->0 acceptance emits a one-cycle press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b1;
      press     <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_p1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        deb_level <= key_p1;
        press     <= ~key_p1;
      end else begin
        deb_cnt <= deb_cnt + DCW'(1);
      end
    end
  end

  assign mode_chg  = (mode_p1 != mode_cap);
  assign state_dbg = state;

  // Sequencer FSM with registered status outputs; a mode change outside IDLE
  // aborts and takes priority over any press in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      blk_sel      <= 3'b001;
      mode_cap     <= 2'b00;
      tmo_cnt      <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      start <= 1'b0;
      if (state != IDLE && mode_chg) begin
        state        <= IDLE;
        op_a         <= '0;
        op_b         <= '0;
        tmo_cnt      <= '0;
        busy         <= 1'b0;
        result_valid <= 1'b0;
        timeout_err  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            blk_sel  <= mode_to_sel(mode_p1);
            mode_cap <= mode_p1;
            if (press) begin
              op_a  <= data_p1;
              state <= GET_B;
            end
          end
          GET_B: begin
            if (press) begin
              op_b  <= data_p1;
              state <= START;
              start <= 1'b1;
              busy  <= 1'b1;
            end
          end
          START: begin
            tmo_cnt <= '0;
            state   <= RUN;
          end
          RUN: begin
            if ((done & blk_sel) != 3'b000) begin
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
              state       <= ERR;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TCW'(1);
            end
          end
          DONE, ERR: begin
            if (press) begin
              state        <= IDLE;
              op_a         <= '0;
              op_b         <= '0;
              result_valid <= 1'b0;
              timeout_err  <= 1'b0;
            end
          end
          default: begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
